// File: rtl/spi_pkg.sv
// Shared definitions for the SPI subordinate: controller states, byte width
// and the default synchronizer depth.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    localparam int BYTE_W          = 8;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input; resets to the line's
// idle level so no spurious edge is seen when reset releases.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_sub.sv
// SPI subordinate (miso driven on sclk rise, mosi sampled on sclk fall) with a
// one-byte transmit holding buffer, oversampled by clk through synchronizers.
//   state  | meaning
//   IDLE   | cs_n high; miso held 0, partial-byte state cleared
//   ACTIVE | cs_n low; bytes shifted on synchronized sclk edges
module spi_sub
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (sclk),
        .o_q   (w_sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (cs_n),
        .o_q   (w_cs_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (mosi),
        .o_q   (w_mosi_s)
    );

    spi_state_t        r_state;
    spi_state_t        w_state_nxt;
    logic              r_sclk_d;
    logic              r_rise;
    logic              r_fall;
    logic [2:0]        r_bit_cnt;
    logic [BYTE_W-1:0] r_tx_shift;
    logic [BYTE_W-2:0] r_rx_shift;
    logic [BYTE_W-1:0] r_buf;
    logic              r_buf_full;
    logic              r_miso;
    logic [BYTE_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_tx_underrun;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!w_cs_s) w_state_nxt = ACTIVE;
            ACTIVE:  if (w_cs_s)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Edge pulses are registered, giving a fixed SYNC_STAGES+2 pin-to-output latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk_d      <= 1'b0;
            r_rise        <= 1'b0;
            r_fall        <= 1'b0;
            r_bit_cnt     <= 3'd0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_buf         <= '0;
            r_buf_full    <= 1'b0;
            r_miso        <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_sclk_d      <= w_sclk_s;
            r_rise        <= w_sclk_s & ~r_sclk_d;
            r_fall        <= ~w_sclk_s & r_sclk_d;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;

            if (tx_load && !r_buf_full) begin
                r_buf      <= tx_data;
                r_buf_full <= 1'b1;
            end

            if (r_state == IDLE) begin
                r_miso     <= 1'b0;
                r_bit_cnt  <= 3'd0;
                r_rx_shift <= '0;
            end else begin
                if (r_rise) begin
                    if (r_bit_cnt == 3'd0) begin
                        // Byte start: a same-cycle tx_load only fills the buffer for the next byte.
                        if (r_buf_full) begin
                            r_miso     <= r_buf[BYTE_W-1];
                            r_tx_shift <= {r_buf[BYTE_W-2:0], 1'b0};
                            r_buf_full <= 1'b0;
                        end else begin
                            r_miso        <= 1'b0;
                            r_tx_shift    <= '0;
                            r_tx_underrun <= 1'b1;
                        end
                    end else begin
                        r_miso     <= r_tx_shift[BYTE_W-1];
                        r_tx_shift <= {r_tx_shift[BYTE_W-2:0], 1'b0};
                    end
                end
                if (r_fall) begin
                    r_rx_shift <= {r_rx_shift[BYTE_W-3:0], w_mosi_s};
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_rx_data  <= {r_rx_shift, w_mosi_s};
                        r_rx_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign miso        = r_miso;
    assign tx_ready    = ~r_buf_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_tx_underrun;
    assign busy        = (r_state == ACTIVE);

endmodule

// File: doc/spi_sub.md
SPI_SUB -- requirements
Module: spi_sub

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on sclk, cs_n and mosi; legal range 2..3.
REQ-002 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-003 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 Port sclk, input, 1: SPI serial clock from the main; asynchronous to clk; idles low.
REQ-005 Port cs_n, input, 1: chip select from the main, active-low; asynchronous to clk.
REQ-006 Port mosi, input, 1: serial data from the main, MSB first.
REQ-007 Port miso, output, 1: serial data to the main, MSB first.
REQ-008 Port tx_data, input, 8: next byte to return to the main.
REQ-009 Port tx_load, input, 1: write strobe for tx_data; accepted only when tx_ready=1.
REQ-010 Port tx_ready, output, 1: high when the transmit holding buffer is empty.
REQ-011 Port rx_data, output, 8: last complete byte received; held until the next byte completes.
REQ-012 Port rx_valid, output, 1: one-clk pulse when rx_data updates.
REQ-013 Port tx_underrun, output, 1: one-clk pulse when a byte starts with the holding buffer empty.
REQ-014 Port busy, output, 1: high while in state ACTIVE.

Function
REQ-015 sclk, cs_n and mosi SHALL each pass through SYNC_STAGES flops; sclk edges SHALL be detected from the last two synchronized samples.
REQ-016 sclk frequency SHALL be at most clk/8; behaviour above that rate is undefined.
REQ-017 State machine: IDLE -> ACTIVE on synchronized cs_n low; ACTIVE -> IDLE on synchronized cs_n high; no other transitions.
REQ-018 In ACTIVE, each synchronized sclk rising edge SHALL drive miso with the current shift-register MSB and then shift left; the first rising edge of a byte presents bit 7.
REQ-019 In ACTIVE, each synchronized sclk falling edge SHALL shift synchronized mosi into the receive register LSB and increment a 3-bit bit counter.
REQ-020 When the bit counter wraps 7 -> 0, rx_data SHALL load the 8 assembled bits and rx_valid SHALL pulse in the same clk cycle; latency from the sclk falling edge at the pin is SYNC_STAGES+2 clk cycles.
REQ-021 Byte start is the first rising sclk edge with bit counter 0; the shift register SHALL load from the holding buffer if full (buffer then empties, tx_ready=1 next cycle), otherwise load 0x00 and pulse tx_underrun.
REQ-022 tx_load with tx_ready=1 SHALL fill the holding buffer next cycle; tx_load with tx_ready=0 SHALL be ignored and the buffer unchanged.
REQ-023 tx_load coinciding with a byte start on an empty buffer SHALL NOT bypass to the shift register; the byte starts as underrun and the loaded data is kept for the next byte.
REQ-024 Consecutive bytes within one cs_n low period SHALL be handled back-to-back with no gap required.
REQ-025 cs_n deasserting mid-byte SHALL discard the partial byte, clear the bit counter, give no rx_valid, and leave the holding buffer untouched.
REQ-026 In IDLE, miso SHALL be driven 0.

Reset
REQ-027 While rst_n=0 at a clk edge: state IDLE, miso=0, rx_data=0x00, rx_valid=0, tx_underrun=0, busy=0, tx_ready=1, holding buffer empty, bit counter 0, synchronizers set to idle levels (sclk 0, cs_n 1, mosi 0).
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no rx_valid; after release, a new transfer requires cs_n high then low.

Structure
REQ-029 Shared package spi_pkg SHALL hold the state enum (IDLE, ACTIVE), the byte width constant (8) and the SYNC_STAGES default.
REQ-030 One sub-module spi_sync (parameterized multi-flop synchronizer) SHALL be instantiated once per asynchronous input.

Verification
REQ-031 Load 0xA5, main sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C with one rx_valid pulse; tx_ready returns to 1.
REQ-032 Two back-to-back bytes under one cs_n low, buffer 0x81 then 0x7E reloaded between bytes -> main receives 0x81, 0x7E; two rx_valid pulses.
REQ-033 No tx_load before a transfer -> miso all 0, one tx_underrun pulse, rx_data still captured correctly.
REQ-034 cs_n high after 5 sclk cycles, then a full byte 0xF0 -> no rx_valid for the partial byte; rx_data=0xF0 for the full one.
REQ-035 rst_n low after 4 bits of a byte -> all outputs at reset values next cycle, no rx_valid; next full transfer correct.
REQ-036 tx_load while tx_ready=0 with 0x11 (buffer holds 0x22) -> main receives 0x22.
